// File: rtl/memory_access_stage.sv
// Memory access stage of an in-order pipeline.
// Non-memory ops pass straight to the MEM/WB register. Loads and stores are
// latched, issued on the data bus from the WAIT state, and written back when
// the bus completes. Misaligned or illegal accesses never reach the bus: they
// are flagged with misalign and written back with register writes suppressed.
//
// Handshakes:
//   EX->MEM: the slot presented with ex_valid=1 is taken on a rising edge
//     only while mem_stall=0. While mem_stall=1 the upstream stage holds
//     every EX/MEM input stable.
//   MEM->bus: dmem_req stays high for the whole access. dmem_ready is a
//     single-cycle completion pulse carrying dmem_rdata. It is sampled only
//     while dmem_req=1 and is ignored otherwise.
//   MEM->WB: wb_valid is a one-cycle qualifier for the registered bundle.
//     There is no back-pressure from writeback.
module memory_access_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic [2:0]       funct3,
    input  logic             mem_rd_en,
    input  logic             mem_wr_en,
    input  logic             reg_wr_en,
    input  logic [4:0]       rd,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [1:0]       wb_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             mem_stall,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data_mem,
    output logic [WIDTH-1:0] wb_data_alu,
    output logic             wb_reg_wr_en,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_pc_plus4,
    output logic [1:0]       wb_sel_o,
    output logic             misalign,
    output logic             dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Access latched at acceptance and held for the whole bus transaction.
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] sdata_q;
    logic [2:0]       f3_q;
    logic             wr_q;
    logic             rwe_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] pc4_q;
    logic [1:0]       sel_q;

    logic             is_mem;
    logic             bad_op;
    logic             accept;
    logic             go_wait;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [WIDTH-1:0] load_data;

    assign is_mem  = mem_rd_en | mem_wr_en;
    assign accept  = (state_q == S_IDLE) && ex_valid;
    assign go_wait = accept && is_mem && !bad_op;

    // Flag a misaligned address or an unsupported size code for the incoming op.
    always_comb begin
        bad_op = 1'b0;
        if (mem_rd_en) begin
            case (funct3)
                3'b000, 3'b100: bad_op = 1'b0;
                3'b001, 3'b101: bad_op = alu_result[0];
                3'b010:         bad_op = |alu_result[1:0];
                default:        bad_op = 1'b1;
            endcase
        end else if (mem_wr_en) begin
            case (funct3)
                3'b000:  bad_op = 1'b0;
                3'b001:  bad_op = alu_result[0];
                3'b010:  bad_op = |alu_result[1:0];
                default: bad_op = 1'b1;
            endcase
        end
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter WAIT on a legal memory op, leave on bus completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_wait) state_d = S_WAIT;
            S_WAIT:  if (dmem_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs: bus request, stall and debug view.
    always_comb begin
        dmem_req  = (state_q == S_WAIT);
        mem_stall = (state_q == S_WAIT);
        dmem_we   = (state_q == S_WAIT) && wr_q;
        dbg_state = (state_q == S_WAIT);
    end

    // Capture the access and its writeback sideband when entering WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            sdata_q <= '0;
            f3_q    <= 3'b000;
            wr_q    <= 1'b0;
            rwe_q   <= 1'b0;
            rd_q    <= 5'd0;
            pc4_q   <= '0;
            sel_q   <= 2'b00;
        end else if (go_wait) begin
            addr_q  <= alu_result;
            sdata_q <= store_data;
            f3_q    <= funct3;
            wr_q    <= mem_wr_en;
            rwe_q   <= reg_wr_en;
            rd_q    <= rd;
            pc4_q   <= pc_plus4;
            sel_q   <= wb_sel;
        end
    end

    assign dmem_addr = {addr_q[WIDTH-1:2], 2'b00};

    // Store lane steering: replicate the datum across the word, enable its lanes.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = sdata_q;
        if (wr_q) begin
            case (f3_q[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << addr_q[1:0];
                    dmem_wdata = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << addr_q[1:0];
                    dmem_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = sdata_q;
                end
            endcase
        end
    end

    // Load extraction: pick the addressed byte/half and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_byte = dmem_rdata[7:0];
            2'b01:   lane_byte = dmem_rdata[15:8];
            2'b10:   lane_byte = dmem_rdata[23:16];
            default: lane_byte = dmem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = '0;
        if (!wr_q) begin
            case (f3_q)
                3'b000:  load_data = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
                3'b001:  load_data = {{(WIDTH-16){lane_half[15]}}, lane_half};
                3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane_byte};
                3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane_half};
                default: load_data = dmem_rdata;
            endcase
        end
    end

    // MEM/WB register: direct ops and rejected accesses from IDLE, bus results from WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            misalign     <= 1'b0;
            wb_data_mem  <= '0;
            wb_data_alu  <= '0;
            wb_reg_wr_en <= 1'b0;
            wb_rd        <= 5'd0;
            wb_pc_plus4  <= '0;
            wb_sel_o     <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (accept && !go_wait) begin
                wb_valid     <= 1'b1;
                misalign     <= is_mem;
                wb_data_mem  <= '0;
                wb_data_alu  <= alu_result;
                wb_reg_wr_en <= reg_wr_en & ~is_mem;
                wb_rd        <= rd;
                wb_pc_plus4  <= pc_plus4;
                wb_sel_o     <= wb_sel;
            end else if ((state_q == S_WAIT) && dmem_ready) begin
                wb_valid     <= 1'b1;
                wb_data_mem  <= load_data;
                wb_data_alu  <= addr_q;
                wb_reg_wr_en <= rwe_q;
                wb_rd        <= rd_q;
                wb_pc_plus4  <= pc4_q;
                wb_sel_o     <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases plus randomized traffic,
// with writeback and bus activity checked against queued expectations.
module tb_memory_access_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        reg_wr_en;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [1:0]  wb_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data_mem;
    logic [31:0] wb_data_alu;
    logic        wb_reg_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc_plus4;
    logic [1:0]  wb_sel_o;
    logic        misalign;
    logic        dbg_state;

    memory_access_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .reg_wr_en(reg_wr_en),
        .rd(rd), .pc_plus4(pc_plus4), .wb_sel(wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .wb_valid(wb_valid),
        .wb_data_mem(wb_data_mem), .wb_data_alu(wb_data_alu),
        .wb_reg_wr_en(wb_reg_wr_en), .wb_rd(wb_rd), .wb_pc_plus4(wb_pc_plus4),
        .wb_sel_o(wb_sel_o), .misalign(misalign), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    // wb bundle: {misalign, reg_wr_en, rd[5], pc4[32], sel[2], alu[32], mem[32]}
    logic [104:0] exp_q[$];
    // bus: {is_store, we, addr[32], be[4], wdata[32]}
    logic [69:0]  bus_q[$];

    int          force_wait = -1;
    bit          force_rdata_en = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    bit          force_idle_ready = 1'b0;

    // current op fields
    int          t_kind;   // 0 alu, 1 load, 2 store
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [31:0] t_sdata;
    logic        t_rwe;
    logic [4:0]  t_rd;
    logic [31:0] t_pc4;
    logic [1:0]  t_sel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a >> 2) * 32'h9E37_79B1;
        return w ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: expected writeback and bus transaction for the current op.
    task automatic model_push(input bit push_wb);
        longint      a, sz, off, val, mask;
        bit          legal, bad, sgn;
        logic [31:0] word, wd, dm, wa;
        logic [3:0]  be;
        a   = longint'(t_addr);
        off = a % 4;
        if (t_kind == 0) begin
            if (push_wb) exp_q.push_back({1'b0, t_rwe, t_rd, t_pc4, t_sel, t_addr, 32'h0});
            return;
        end
        if (t_kind == 1) legal = (t_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else             legal = (t_f3 inside {3'd0, 3'd1, 3'd2});
        sz  = longint'(1) << (int'(t_f3) % 4);
        bad = !legal || ((a % sz) != 0);
        if (bad) begin
            if (push_wb) exp_q.push_back({1'b1, 1'b0, t_rd, t_pc4, t_sel, t_addr, 32'h0});
            return;
        end
        wa = 32'(a - off);
        if (t_kind == 1) begin
            be = 4'hF;
            wd = 32'h0;
            word = force_rdata_en ? force_rdata : mem_word(wa);
            mask = (longint'(1) << (8 * sz)) - 1;
            val  = (longint'(word) >> (8 * off)) & mask;
            sgn  = (t_f3 < 3'd4) && (sz < 4);
            if (sgn && (val >= (longint'(1) << (8 * sz - 1)))) val = val - (longint'(1) << (8 * sz));
            dm = 32'(val);
        end else begin
            be = 4'(((longint'(1) << sz) - 1) << off);
            if (sz == 1)      wd = 32'((longint'(t_sdata) % 256) * 32'h0101_0101);
            else if (sz == 2) wd = 32'((longint'(t_sdata) % 65536) * 32'h0001_0001);
            else              wd = t_sdata;
            dm = 32'h0;
        end
        bus_q.push_back({(t_kind == 2), (t_kind == 2), wa, be, wd});
        if (push_wb) exp_q.push_back({1'b0, t_rwe, t_rd, t_pc4, t_sel, t_addr, dm});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic rwe, input logic [4:0] rdv,
                          input logic [31:0] pc4, input logic [1:0] sel);
        t_kind = kind; t_f3 = f3; t_addr = addr; t_sdata = sdata;
        t_rwe = rwe; t_rd = rdv; t_pc4 = pc4; t_sel = sel;
    endtask

    task automatic drive_idle();
        ex_valid   = 1'b0;
        alu_result = $urandom;
        store_data = $urandom;
        funct3     = 3'($urandom_range(0, 7));
        mem_rd_en  = 1'($urandom_range(0, 1));
        mem_wr_en  = ~mem_rd_en;
        reg_wr_en  = 1'($urandom_range(0, 1));
        rd         = 5'($urandom_range(0, 31));
        pc_plus4   = $urandom;
        wb_sel     = 2'($urandom_range(0, 3));
    endtask

    // Called at a negedge; returns at the negedge after the slot is accepted.
    task automatic issue(input bit push_wb);
        int guard;
        ex_valid   = 1'b1;
        alu_result = t_addr;
        store_data = t_sdata;
        funct3     = t_f3;
        mem_rd_en  = (t_kind == 1);
        mem_wr_en  = (t_kind == 2);
        reg_wr_en  = t_rwe;
        rd         = t_rd;
        pc_plus4   = t_pc4;
        wb_sel     = t_sel;
        guard = 0;
        while (mem_stall && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL issue_stall_timeout actual=stalled required=released");
        end
        @(posedge clk);
        model_push(push_wb);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (mem_stall && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=stalled required=idle");
        end
        @(negedge clk);
    endtask

    // ---------------- bus responder ----------------
    initial begin : responder
        bit          in_txn;
        int          wait_left;
        logic [69:0] bx;
        in_txn = 1'b0;
        wait_left = 0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dmem_ready = 1'b0;
            if (dmem_req && rst_n) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_unexpected addr=%h be=%h we=%b", dmem_addr, dmem_be, dmem_we);
                    end else begin
                        bx = bus_q.pop_front();
                        if (dmem_we !== bx[68] || dmem_addr !== bx[67:36] || dmem_be !== bx[35:32] ||
                            (bx[69] && dmem_wdata !== bx[31:0])) begin
                            errors++;
                            $display("FAIL bus_request actual we=%b addr=%h be=%h wdata=%h required we=%b addr=%h be=%h wdata=%h",
                                     dmem_we, dmem_addr, dmem_be, dmem_wdata, bx[68], bx[67:36], bx[35:32], bx[31:0]);
                        end
                    end
                end
                if (wait_left == 0) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = force_rdata_en ? force_rdata : mem_word(dmem_addr);
                    in_txn = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                in_txn = 1'b0;
                dmem_ready = force_idle_ready || ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // ---------------- writeback monitor ----------------
    initial begin : monitor
        logic [104:0] got, expv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_valid) begin
                    checks++;
                    got = {misalign, wb_reg_wr_en, wb_rd, wb_pc_plus4, wb_sel_o, wb_data_alu, wb_data_mem};
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected actual=%h required=no writeback", got);
                    end else begin
                        expv = exp_q.pop_front();
                        if (got !== expv) begin
                            errors++;
                            $display("FAIL wb_bundle actual=%h required=%h", got, expv);
                        end
                    end
                end else if (misalign) begin
                    checks++;
                    errors++;
                    $display("FAIL misalign_stray actual=1 required=0 (no writeback)");
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int cnt;
        int guard;
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_dbg_state", 32'(dbg_state), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_mem_stall", 32'(mem_stall), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_wb_reg_wr_en", 32'(wb_reg_wr_en), 32'h0);
        check("rst_wb_data_mem", wb_data_mem, 32'h0);
        check("rst_wb_data_alu", wb_data_alu, 32'h0);
        check("rst_wb_rd", 32'(wb_rd), 32'h0);
        check("rst_wb_pc_plus4", wb_pc_plus4, 32'h0);
        check("rst_wb_sel_o", 32'(wb_sel_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD: one-cycle writeback, no stall
        set_op(0, 3'b000, 32'h10, 32'h0, 1'b1, 5'd5, 32'h1004, 2'b00);
        issue(1'b1);
        check("add_no_stall", 32'(mem_stall), 32'h0);
        check("add_wb_valid", 32'(wb_valid), 32'h1);
        check("add_wb_rd", 32'(wb_rd), 32'd5);

        // LB at 0x103 with two WAIT cycles
        force_wait = 1;
        force_rdata_en = 1'b1;
        force_rdata = 32'h80FF_FFFF;
        set_op(1, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7, 32'h1008, 2'b01);
        issue(1'b1);
        check("lb_dmem_addr", dmem_addr, 32'h100);
        cnt = 0;
        guard = 0;
        while (mem_stall && guard < 20) begin
            cnt++;
            @(negedge clk);
            guard++;
        end
        check("lb_stall_cycles", 32'(cnt), 32'd2);
        check("lb_wb_data_mem", wb_data_mem, 32'hFFFF_FF80);
        force_wait = -1;
        force_rdata_en = 1'b0;
        @(negedge clk);

        // SH at 0x102
        set_op(2, 3'b001, 32'h102, 32'h1234_ABCD, 1'b0, 5'd0, 32'h100C, 2'b00);
        issue(1'b1);
        check("sh_dmem_be", 32'(dmem_be), 32'hC);
        check("sh_dmem_wdata", dmem_wdata, 32'hABCD_ABCD);
        check("sh_dmem_we", 32'(dmem_we), 32'h1);
        wait_idle();

        // LW at 0x101: rejected without bus traffic
        set_op(1, 3'b010, 32'h101, 32'h0, 1'b1, 5'd9, 32'h1010, 2'b01);
        issue(1'b1);
        check("lw_mis_no_req", 32'(dmem_req), 32'h0);
        check("lw_mis_pulse", 32'(misalign), 32'h1);
        check("lw_mis_wb_valid", 32'(wb_valid), 32'h1);
        check("lw_mis_wb_reg_wr_en", 32'(wb_reg_wr_en), 32'h0);
        @(negedge clk);
        check("lw_mis_pulse_end", 32'(misalign), 32'h0);

        // Reset in the middle of a WAIT, then a stray ready
        force_wait = 5;
        set_op(1, 3'b000, 32'h300, 32'h0, 1'b1, 5'd3, 32'h1014, 2'b01);
        issue(1'b0);
        check("rstwait_in_wait", 32'(dbg_state), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwait_state", 32'(dbg_state), 32'h0);
        check("rstwait_req", 32'(dmem_req), 32'h0);
        check("rstwait_stall", 32'(mem_stall), 32'h0);
        check("rstwait_wb_valid", 32'(wb_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        force_idle_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstwait_post_state", 32'(dbg_state), 32'h0);
            check("rstwait_post_wb_valid", 32'(wb_valid), 32'h0);
        end
        force_idle_ready = 1'b0;
        force_wait = -1;

        // LW then ADD back to back, ready on first WAIT cycle
        force_wait = 0;
        set_op(1, 3'b010, 32'h200, 32'h0, 1'b1, 5'd11, 32'h1018, 2'b01);
        issue(1'b1);
        set_op(0, 3'b000, 32'h55, 32'h0, 1'b1, 5'd12, 32'h101C, 2'b00);
        issue(1'b1);
        force_wait = -1;
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            set_op(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), a, $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   2'($urandom_range(0, 3)));
            issue(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);

        check("drain_wb_queue", 32'(exp_q.size()), 32'h0);
        check("drain_bus_queue", 32'(bus_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; the block is specified only for 32.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ex_valid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 SHALL have alu_result  input  WIDTH  ALU result / effective address.
REQ-006 SHALL have store_data  input  WIDTH  rs2 value for stores.
REQ-007 SHALL have funct3  input  3  load/store size and sign code.
REQ-008 SHALL have mem_rd_en, mem_wr_en  input  1 each  load / store op; never both high.
REQ-009 SHALL have reg_wr_en, rd[4:0], pc_plus4[WIDTH], wb_sel[2]  input  sideband passed to writeback.
REQ-010 SHALL have dmem_req, dmem_we  output  1 each  bus request / write strobe.
REQ-011 SHALL have dmem_addr, dmem_wdata  output  WIDTH each  word-aligned address / lane-shifted write data.
REQ-012 SHALL have dmem_be  output  4  byte enables.
REQ-013 SHALL have dmem_ready  input  1 and dmem_rdata  input  WIDTH  single-cycle completion pulse with read word.
REQ-014 SHALL have mem_stall  output  1  upstream holds the EX/MEM slot while high.
REQ-015 SHALL have wb_valid, wb_data_mem, wb_data_alu, wb_reg_wr_en, wb_rd, wb_pc_plus4, wb_sel_o  output  registered MEM/WB bundle.
REQ-016 SHALL have misalign  output  1  one-cycle pulse flagging a misaligned or illegal access.

Function
REQ-017 SHALL implement FSM IDLE/WAIT; the slot is accepted only in IDLE with ex_valid=1.
REQ-018 Non-memory op SHALL appear on the MEM/WB bundle with wb_valid=1 on the next edge (latency 1).
REQ-019 Memory op SHALL latch address, data, funct3 and sideband on acceptance and enter WAIT; dmem_req=1 throughout WAIT.
REQ-020 mem_stall SHALL equal (state==WAIT), including the cycle in which dmem_ready is sampled.
REQ-021 In WAIT with dmem_ready=1 SHALL register the result, set wb_valid=1 next cycle, and return to IDLE; total latency = bus wait + 1.
REQ-022 wb_valid SHALL be 0 in every cycle following a WAIT cycle without dmem_ready, and after IDLE with ex_valid=0.
REQ-023 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we = latched mem_wr_en.
REQ-024 Stores: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<addr[1:0], half replicated x2; SW be=1111.
REQ-025 Loads SHALL use be=1111 and extract by latched addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-026 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Illegal: load funct3 011/110/111, store funct3 >=011.
REQ-027 A misaligned or illegal op SHALL issue no bus request, stay in IDLE, pulse misalign, and produce wb_valid=1 with wb_reg_wr_en=0.
REQ-028 dmem_ready in IDLE SHALL be ignored.
REQ-029 wb_data_alu SHALL carry alu_result for every op; wb_data_mem SHALL be 0 for non-load ops.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, dmem_req=0, mem_stall=0, misalign=0, and every MEM/WB output to 0.
REQ-031 Reset during WAIT SHALL abandon the access; a dmem_ready after release SHALL have no effect.

Verification
REQ-032 ADD, alu_result=0x10, rd=5, ex_valid=1 -> next cycle wb_valid=1, wb_data_alu=0x10, wb_rd=5, mem_stall=0.
REQ-033 LB addr=0x103, rdata=0x80FF_FF_FF, ready after 2 WAIT cycles -> dmem_addr=0x100, mem_stall high 2 cycles, wb_data_mem=0xFFFFFF80.
REQ-034 SH addr=0x102, store_data=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-035 LW addr=0x101 -> no dmem_req, misalign pulse, wb_valid=1, wb_reg_wr_en=0.
REQ-036 rst_n=0 in WAIT, release, then dmem_ready=1 -> state IDLE, wb_valid=0, no writeback.
REQ-037 Back-to-back LW then ADD, ready on first WAIT cycle -> ADD held by stall, accepted after IDLE return, both written back in order.
